// File: rtl/fp_dot_accumulator.sv
// -----------------------------------------------------------------------------
// fp_dot_accumulator
//
// Streaming float32 accumulator placed after the neuron's floating-point
// multiplier. A run starts with a start pulse and a length. The block then
// accepts exactly that many products over a valid/ready handshake and adds
// each one into a running float32 total. When the run is complete it presents
// the total on an output handshake.
//
// The adder uses the same reduced float semantics as the multiplier:
//   - A zero exponent is treated as signed zero. Denormals are flushed.
//   - Alignment truncates, with no guard bits, and so does normalization.
//   - Overflow saturates to signed infinity. An infinite operand forces
//     infinity.
//   - NaN is never produced.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   start      in   begin a run; honoured only while idle
//   len        in   number of products in the run, sampled with start
//   product    in   float32 product from the multiplier
//   in_valid   in   product is valid
//   in_ready   out  a product is accepted this cycle (ACC state)
//   sum        out  accumulated float32 total, driven from the accumulator
//   sum_valid  out  total is complete (DONE state)
//   sum_ready  in   downstream consumes the total
//   busy       out  block is not idle
// -----------------------------------------------------------------------------
module fp_dot_accumulator #(
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic [31:0]          product,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [31:0]          sum,
  output logic                 sum_valid,
  input  logic                 sum_ready,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [31:0]          r_acc;
  logic [LEN_WIDTH-1:0] r_count;
  logic                 w_accept;
  logic                 w_start_run;
  logic [31:0]          w_fadd;

  // ---------------------------------------------------------------------------
  // Single-cycle float32 adder with flush-to-zero, truncation and saturation.
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic        sa, sb, sl;
    logic [7:0]  ea, eb, el, es, d;
    logic [22:0] fa, fb;
    logic [23:0] ml, ms_raw, ms, diff, mant;
    logic [24:0] s25;
    logic [4:0]  lz;
    logic        found;
    logic [9:0]  en;
    logic [31:0] r;

    sa = a[31]; ea = a[30:23]; fa = a[22:0];
    sb = b[31]; eb = b[30:23]; fb = b[22:0];
    r      = 32'h0;
    sl     = 1'b0;
    el     = 8'd0;
    es     = 8'd0;
    ml     = 24'd0;
    ms_raw = 24'd0;
    ms     = 24'd0;
    diff   = 24'd0;
    mant   = 24'd0;
    s25    = 25'd0;
    lz     = 5'd0;
    found  = 1'b0;
    en     = 10'd0;
    d      = 8'd0;

    if (ea == 8'hFF) begin
      // Infinity in a wins, including when both are infinite.
      r = {sa, 8'hFF, 23'd0};
    end else if (eb == 8'hFF) begin
      r = {sb, 8'hFF, 23'd0};
    end else if (ea == 8'd0) begin
      // Zero plus x passes x through untouched.
      r = b;
    end else if (eb == 8'd0) begin
      r = a;
    end else begin
      // Order the operands by magnitude. The exponent/fraction pair compares
      // as an unsigned magnitude.
      if ({ea, fa} >= {eb, fb}) begin
        sl = sa; el = ea; es = eb;
        ml = {1'b1, fa}; ms_raw = {1'b1, fb};
      end else begin
        sl = sb; el = eb; es = ea;
        ml = {1'b1, fb}; ms_raw = {1'b1, fa};
      end

      d  = el - es;
      ms = (d >= 8'd24) ? 24'd0 : (ms_raw >> d);

      if (sa == sb) begin
        s25 = {1'b0, ml} + {1'b0, ms};
        if (s25[24]) begin
          mant = s25[24:1];
          en   = {2'b00, el} + 10'd1;
        end else begin
          mant = s25[23:0];
          en   = {2'b00, el};
        end
        if (en >= 10'd255) r = {sl, 8'hFF, 23'd0};
        else               r = {sl, en[7:0], mant[22:0]};
      end else begin
        // The larger operand is subtracted from, so the difference is never
        // negative.
        diff = ml - ms;
        if (diff == 24'd0) begin
          r = 32'h0;
        end else begin
          for (int i = 23; i >= 0; i--) begin
            if (!found) begin
              if (diff[i]) found = 1'b1;
              else         lz    = lz + 5'd1;
            end
          end
          mant = diff << lz;
          en   = {2'b00, el} - {5'b00000, lz};
          if ($signed(en) <= 10'sd0) r = {sl, 31'd0};
          else                       r = {sl, en[7:0], mant[22:0]};
        end
      end
    end
    return r;
  endfunction

  assign w_fadd      = fadd(r_acc, product);
  assign w_accept    = (r_state == S_ACC) && in_valid;
  assign w_start_run = (r_state == S_IDLE) && start;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every register in
  // this block samples the values from before the edge. This is the same for
  // all of them, whatever order they are written in.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= 32'h0;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_start_run) begin
        r_acc   <= 32'h0;
        r_count <= len;
      end else if (w_accept) begin
        r_acc   <= w_fadd;
        r_count <= r_count - 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output decode. The handshake outputs depend only on the
  // registered state, so no input feeds through to them combinationally.
  // ---------------------------------------------------------------------------
  // NOTE: every output is assigned a default before the case statement, so
  // no path can leave a value unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    sum_valid    = 1'b0;
    busy         = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_next_state = (len == '0) ? S_DONE : S_ACC;
        end
      end
      S_ACC: begin
        in_ready = 1'b1;
        if (in_valid && (r_count == {{(LEN_WIDTH-1){1'b0}}, 1'b1})) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        sum_valid = 1'b1;
        if (sum_ready) w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign sum = r_acc;

endmodule

// File: doc/fp_dot_accumulator.md
# fp_dot_accumulator

Streaming IEEE-754 single-precision accumulator that sits directly downstream of the floating-point multiplier in a neuron's dot-product path. It consumes one product per cycle over a valid/ready handshake, sums a programmed number of products into a running float32 total, and presents the finished sum on an output handshake. It uses the same simplified float semantics as the multiplier: flush-to-zero, truncation, and infinity saturation.

## Interface
- LEN_WIDTH, 8, width of the vector-length input and the internal countdown counter
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a new accumulation; honoured only in IDLE
- len  input  LEN_WIDTH  number of products to accumulate; sampled when start is honoured
- product  input  32  float32 product from the multiplier
- in_valid  input  1  product is valid
- in_ready  output  1  accumulator accepts a product this cycle
- sum  output  32  accumulated float32 result
- sum_valid  output  1  sum is valid
- sum_ready  input  1  downstream consumes sum
- busy  output  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - start=1 and len>0: acc <= 32'h00000000, count <= len, go to ACC.
  - start=1 and len=0: acc <= 0, go to DONE.
- ACC:
  - in_ready=1.
  - When in_valid=1: acc <= fadd(acc, product) and count <= count-1.
  - If count==1 at that accept, go to DONE.
  - When in_valid=0: hold all state; bubbles are allowed.
- DONE:
  - sum_valid=1 and sum=acc.
  - When sum_ready=1, go to IDLE.
  - sum holds stable while sum_ready=0.
- start is ignored in ACC and DONE.
- fadd(a,b), combinational, single cycle:
  - Exponent 0 is treated as signed zero, including denormals. Zero plus x returns x unchanged.
  - If either exponent is FF, the result is {sign of that operand, FF, 0}. If both are FF, the sign of a is used. No NaN is ever produced.
  - Significands are {1, frac}. The smaller-exponent operand is shifted right by the exponent difference, with truncation and no guard bits; a difference of 24 or more gives 0.
  - Equal signs: add into 25 bits. A carry-out shifts right by 1 (truncate) and increments the exponent.
  - Different signs: subtract smaller magnitude from larger; the result takes the sign of the larger.
    - Exact cancellation gives +0 (32'h00000000).
    - Otherwise normalize left until bit 23 is set, decrementing the exponent.
  - Exponent reaching 255 or more gives ±inf {sign, FF, 0}. Exponent ≤ 0 after normalization gives signed zero.
- Reset, including mid-ACC or mid-DONE:
  - state=IDLE, acc=0, count=0.
  - in_ready=0, sum_valid=0, busy=0, sum=32'h0.
  - Any partial sum is discarded.

## Timing
- in_ready, sum_valid and busy are decoded from registered state only; no combinational path from inputs.
- sum is driven directly from the acc register.
- Example sequence, with start sampled at edge 0:
  - ACC from cycle 1.
  - With back-to-back in_valid, products are accepted at edges 1..len.
  - sum_valid is asserted in cycle len+1; start-to-sum_valid latency is len+1 cycles.
- Throughput is one product per cycle. In ACC, in_ready is never deasserted by the block itself.
- The handshake completes at the edge where sum_valid & sum_ready. The earliest next start is sampled in the following cycle, giving a minimum gap of 1 cycle in IDLE between vectors.
- len=0: sum_valid with sum=0 in the cycle after start.
- Maximum vector length is 2^LEN_WIDTH-1.

## Test plan
- Sum of four: reset, start with len=4, then products 3F800000, 40000000, 40400000, 40800000 back-to-back -> sum_valid in cycle 5 with sum=41200000 (10.0). in_ready is high in cycles 1-4 and low in cycle 5.
- Bubbles and backpressure:
  - Stimulus: len=2; products 3FC00000 then BFC00000, with in_valid low for 3 cycles between them; hold sum_ready=0 for 5 cycles.
  - Response: sum=00000000 held stable with sum_valid=1 throughout.
  - A start pulse during DONE is ignored; busy stays 1.
- Saturation and flush: len=2, products 7F7FFFFF, 7F7FFFFF -> sum=7F800000. Then len=2, products 00400000, 3F800000 -> sum=3F800000.
- Zero length: start with len=0 -> sum_valid next cycle, sum=00000000, in_ready never asserted.
- Reset mid-operation:
  - Stimulus: len=4, accept 2 products, assert rst for 1 cycle.
  - Response: next cycle state is IDLE, busy=0, in_ready=0, sum=0.
  - A new len=1 run with product 40A00000 yields sum=40A00000.
- Alignment truncation: len=2, products 4B800000 (2^24) and 3F800000 -> sum=4B800000, because the 1.0 is shifted out.
